display_timings_480p: RTL and testbench

//  Raster timing generator for 640x480 60 Hz. Runs in the pixel clock domain
//  (25.2 MHz) produced by the pixel clock generator. Reset comes from that

---
 rtl/display_timings_480p.sv | 120 ++++++++++++
 tb/tb_display_timings_480p.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timings_480p.sv
// display_timings_480p: 640x480 60 Hz raster timing generator (clk_pix domain).
// Registered sx/sy, hsync, vsync, de, frame and line, all describing one pixel.
// Optional: define DISPLAY_TIMINGS_FRAME_COUNT_EN to add the frame_cnt[15:0] output.
module display_timings_480p #(
  parameter int unsigned CORDW  = 16,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter logic        H_POL  = 1'b0,
  parameter logic        V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_STA  = H_RES + H_FP;
  localparam int unsigned HS_END  = HS_STA + H_SYNC;
  localparam int unsigned VS_STA  = V_RES + V_FP;
  localparam int unsigned VS_END  = VS_STA + V_SYNC;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_RES_C  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_RES_C  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_STA_C = CORDW'(HS_STA);
  localparam logic [CORDW-1:0] HS_END_C = CORDW'(HS_END);
  localparam logic [CORDW-1:0] VS_STA_C = CORDW'(VS_STA);
  localparam logic [CORDW-1:0] VS_END_C = CORDW'(VS_END);
  localparam logic [CORDW-1:0] ONE_C    = CORDW'(1);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             frame_q, frame_d;
  logic             line_q, line_d;

  // Next position, then decode outputs from that same next position so that
  // every registered output describes the pixel presented on sx/sy.
  always_comb begin
    sx_d = sx_q + ONE_C;
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + ONE_C;
    end
    de_d    = (sx_d < H_RES_C) && (sy_d < V_RES_C);
    hsync_d = ((sx_d >= HS_STA_C) && (sx_d < HS_END_C)) ? H_POL : ~H_POL;
    vsync_d = ((sy_d >= VS_STA_C) && (sy_d < VS_END_C)) ? V_POL : ~V_POL;
    frame_d = (sx_d == '0) && (sy_d == '0);
    line_d  = (sx_d == '0);
  end

  // Timing registers; reset parks the raster on the last pixel of the frame.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign frame = frame_q;
  assign line  = line_q;

`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count frames in step with the frame pulse; reads 1 during the first frame.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk_pix) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_display_timings_480p.sv
// Directed bench for display_timings_480p: a default 640x480 instance for
// reset/line/mid-line-reset checks and a small-raster instance for frame-level
// checks (15x9 total, H_POL=1) so full frames run in a few hundred cycles.
module tb_display_timings_480p;

  logic        clk = 1'b0;
  logic        rf  = 1'b1;
  logic        rs  = 1'b1;

  logic [15:0] f_sx, f_sy;
  logic        f_hs, f_vs, f_de, f_fr, f_ln;
  logic [7:0]  s_sx, s_sy;
  logic        s_hs, s_vs, s_de, s_fr, s_ln;
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
  logic [15:0] f_fc, s_fc;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  display_timings_480p u_full (
    .clk_pix(clk), .rst(rf), .sx(f_sx), .sy(f_sy), .hsync(f_hs), .vsync(f_vs),
    .de(f_de), .frame(f_fr), .line(f_ln)
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    , .frame_cnt(f_fc)
`endif
  );

  display_timings_480p #(
    .CORDW(8), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(2), .V_SYNC(2), .V_BP(1), .H_POL(1'b1), .V_POL(1'b0)
  ) u_small (
    .clk_pix(clk), .rst(rs), .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs),
    .de(s_de), .frame(s_fr), .line(s_ln)
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int unsigned de_cnt, hs_cnt, hs_first, hs_last, ln_cnt, vs_cnt;
    int unsigned fr_cnt, fr_last, vs_first_sx, vs_first_sy, de_f0;
    bit          hs_seen, vs_seen;

    // ---- default instance: reset held 5 cycles ----
    rf = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick(1);
      chk("rst_sx", f_sx, 799);
      chk("rst_sy", f_sy, 524);
      chk("rst_de", f_de, 0);
      chk("rst_hsync", f_hs, 1);
      chk("rst_vsync", f_vs, 1);
      chk("rst_frame", f_fr, 0);
      chk("rst_line", f_ln, 0);
    end
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    chk("rst_frame_cnt", f_fc, 0);
`endif
    rf = 1'b0;
    tick(1);
    chk("rel_sx", f_sx, 0);
    chk("rel_sy", f_sy, 0);
    chk("rel_de", f_de, 1);
    chk("rel_frame", f_fr, 1);
    chk("rel_line", f_ln, 1);
    chk("rel_hsync", f_hs, 1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    chk("rel_frame_cnt", f_fc, 1);
`endif

    // ---- default instance: one full line from (0,0) ----
    de_cnt = 0; hs_cnt = 0; hs_first = 0; hs_last = 0; ln_cnt = 0; vs_cnt = 0;
    hs_seen = 1'b0;
    for (int unsigned i = 0; i < 800; i++) begin
      if (f_de) de_cnt++;
      if (!f_hs) begin
        hs_cnt++;
        if (!hs_seen) hs_first = 32'(f_sx);
        hs_seen = 1'b1;
        hs_last = 32'(f_sx);
      end
      if (f_ln) ln_cnt++;
      if (!f_vs) vs_cnt++;
      tick(1);
    end
    chk("line_de_cnt", de_cnt, 640);
    chk("line_hs_cnt", hs_cnt, 96);
    chk("line_hs_first", hs_first, 656);
    chk("line_hs_last", hs_last, 751);
    chk("line_ln_cnt", ln_cnt, 1);
    chk("line_vs_cnt", vs_cnt, 0);
    chk("line2_sx", f_sx, 0);
    chk("line2_sy", f_sy, 1);
    chk("line2_line", f_ln, 1);
    chk("line2_frame", f_fr, 0);

    // ---- default instance: reset mid-frame at (300,1) ----
    tick(300);
    chk("mid_sx", f_sx, 300);
    chk("mid_sy", f_sy, 1);
    rf = 1'b1;
    tick(1);
    chk("midrst_sx", f_sx, 799);
    chk("midrst_sy", f_sy, 524);
    chk("midrst_de", f_de, 0);
    chk("midrst_hsync", f_hs, 1);
    rf = 1'b0;
    tick(1);
    chk("midrel_sx", f_sx, 0);
    chk("midrel_sy", f_sy, 0);
    chk("midrel_frame", f_fr, 1);

    // ---- small instance: reset and release ----
    rs = 1'b1;
    tick(2);
    chk("s_rst_sx", s_sx, 14);
    chk("s_rst_sy", s_sy, 8);
    chk("s_rst_de", s_de, 0);
    chk("s_rst_hsync", s_hs, 0);
    chk("s_rst_vsync", s_vs, 1);
    chk("s_rst_frame", s_fr, 0);
    chk("s_rst_line", s_ln, 0);
    rs = 1'b0;
    tick(1);
    chk("s_rel_sx", s_sx, 0);
    chk("s_rel_sy", s_sy, 0);
    chk("s_rel_frame", s_fr, 1);
    chk("s_rel_de", s_de, 1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    chk("s_fc_first", s_fc, 1);
`endif

    // ---- small instance: two full frames (135 cycles each) ----
    de_cnt = 0; hs_cnt = 0; ln_cnt = 0; vs_cnt = 0; fr_cnt = 0; fr_last = 0;
    de_f0 = 0; vs_seen = 1'b0; vs_first_sx = 99; vs_first_sy = 99;
    for (int unsigned c = 0; c < 270; c++) begin
      if (s_de) begin
        de_cnt++;
        if (c < 135) de_f0++;
      end
      if (s_hs) hs_cnt++;
      if (s_ln) ln_cnt++;
      if (s_fr) begin
        fr_cnt++;
        if (c != 0) fr_last = c;
      end
      if (!s_vs) begin
        vs_cnt++;
        if (!vs_seen) begin
          vs_first_sx = 32'(s_sx);
          vs_first_sy = 32'(s_sy);
        end
        vs_seen = 1'b1;
      end
      tick(1);
    end
    chk("s_fr_cnt", fr_cnt, 2);
    chk("s_fr_gap", fr_last, 135);
    chk("s_vs_cnt", vs_cnt, 60);
    chk("s_vs_first_sx", vs_first_sx, 0);
    chk("s_vs_first_sy", vs_first_sy, 6);
    chk("s_de_frame0", de_f0, 32);
    chk("s_de_total", de_cnt, 64);
    chk("s_hs_cnt", hs_cnt, 54);
    chk("s_ln_cnt", ln_cnt, 18);
    chk("s_f2_sx", s_sx, 0);
    chk("s_f2_sy", s_sy, 0);
    chk("s_f2_frame", s_fr, 1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    chk("s_fc_three", s_fc, 3);
`endif

    // ---- small instance: end of active area (14,3) -> (0,4) ----
    tick(59);
    chk("s_ea_sx", s_sx, 14);
    chk("s_ea_sy", s_sy, 3);
    chk("s_ea_de", s_de, 0);
    tick(1);
    chk("s_vb_sx", s_sx, 0);
    chk("s_vb_sy", s_sy, 4);
    chk("s_vb_de", s_de, 0);
    chk("s_vb_line", s_ln, 1);
    chk("s_vb_frame", s_fr, 0);

    // ---- small instance: frame wrap (14,8) -> (0,0) ----
    tick(74);
    chk("s_fw_sx", s_sx, 14);
    chk("s_fw_sy", s_sy, 8);
    chk("s_fw_frame", s_fr, 0);
    tick(1);
    chk("s_fw2_sx", s_sx, 0);
    chk("s_fw2_sy", s_sy, 0);
    chk("s_fw2_frame", s_fr, 1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    chk("s_fc_four", s_fc, 4);
`endif

    // ---- small instance: one-cycle reset at (5,2) ----
    tick(35);
    chk("s_mid_sx", s_sx, 5);
    chk("s_mid_sy", s_sy, 2);
    rs = 1'b1;
    tick(1);
    chk("s_midrst_sx", s_sx, 14);
    chk("s_midrst_sy", s_sy, 8);
    chk("s_midrst_hsync", s_hs, 0);
    rs = 1'b0;
    tick(1);
    chk("s_midrel_sx", s_sx, 0);
    chk("s_midrel_sy", s_sy, 0);
    chk("s_midrel_frame", s_fr, 1);
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
    chk("s_fc_after_rst", s_fc, 1);

    // ---- frame counter wrap 65535 -> 0 ----
    tick(10);
    force u_small.frame_cnt_q = 16'hFFFF;
    #1;
    release u_small.frame_cnt_q;
    tick(124);
    chk("s_fc_pre_wrap", s_fc, 65535);
    tick(1);
    chk("s_fc_wrap_frame", s_fr, 1);
    chk("s_fc_wrap", s_fc, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
